frame_buffer_reader: RTL and testbench

FRAME_BUFFER_READER -- requirements
Module: frame_buffer_reader

---
 rtl/frame_buffer_reader.sv | 175 +++++++++++++++++
 tb/tb_frame_buffer_reader.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader
//   Streams one frame out of a synchronous-read frame buffer on request.
//   Reads run ahead of the pixel stream through a 2-entry output FIFO, so
//   the stream sustains one pixel per clock and absorbs any backpressure.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   frame_start_i  one-cycle request to stream a frame (accepted in IDLE only)
//   fb_read_o      frame-buffer read strobe
//   fb_addr_o      frame-buffer read address
//   fb_data_i      read data, valid exactly one cycle after fb_read_o
//   pixel_valid_o  output pixel valid
//   pixel_ready_i  downstream ready
//   pixel_data_o   output pixel
//   pixel_sof_o    pixel is address 0
//   pixel_eol_o    pixel is the last of its line
//   busy_o         frame accepted and last pixel not yet transferred
//
// Build option
//   FB_READER_LINE_GAP_EN  when defined, read issue pauses for
//                          LINE_GAP_CYCLES cycles after each line except
//                          the last; output keeps draining during the gap.

module frame_buffer_reader #(
    parameter int PIXEL_WIDTH      = 4,
    parameter int PIXELS_PER_LINE  = 160,
    parameter int LINES_PER_FRAME  = 120,
    parameter int LINE_GAP_CYCLES  = 4,
    localparam int PIXELS_PER_FRAME = PIXELS_PER_LINE * LINES_PER_FRAME,
    localparam int FB_ADDR_WIDTH    = $clog2(PIXELS_PER_FRAME)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     frame_start_i,
    output logic                     fb_read_o,
    output logic [FB_ADDR_WIDTH-1:0] fb_addr_o,
    input  logic [PIXEL_WIDTH-1:0]   fb_data_i,
    output logic                     pixel_valid_o,
    input  logic                     pixel_ready_i,
    output logic [PIXEL_WIDTH-1:0]   pixel_data_o,
    output logic                     pixel_sof_o,
    output logic                     pixel_eol_o,
    output logic                     busy_o
);

    localparam int COL_W   = (PIXELS_PER_LINE > 1) ? $clog2(PIXELS_PER_LINE) : 1;
    localparam int GAP_W   = (LINE_GAP_CYCLES > 0) ? $clog2(LINE_GAP_CYCLES + 1) : 1;
    localparam int ENTRY_W = PIXEL_WIDTH + 2;

    localparam logic [FB_ADDR_WIDTH-1:0] LAST_ADDR = FB_ADDR_WIDTH'(PIXELS_PER_FRAME - 1);
    localparam logic [COL_W-1:0]         LAST_COL  = COL_W'(PIXELS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t                   r_state;
    logic [FB_ADDR_WIDTH-1:0] r_addr;
    logic [COL_W-1:0]         r_col;
    logic [GAP_W-1:0]         r_gap;
    logic                     r_inflight;
    logic                     r_if_sof;
    logic                     r_if_eol;

    logic [ENTRY_W-1:0]       r_mem [2];
    logic                     r_wr_ptr;
    logic                     r_rd_ptr;
    logic [1:0]               r_count;

    logic                     w_empty;
    logic                     w_valid;
    logic [ENTRY_W-1:0]       w_head;
    logic                     w_pop;
    logic                     w_fifo_pop;
    logic                     w_push;
    logic [2:0]               w_pending;
    logic                     w_read;

    // The read in flight counts as a FIFO entry whose data arrives this
    // cycle on fb_data_i. When nothing is stored it is presented directly,
    // which gives the two-cycle start latency; if it is not taken it is
    // written into the FIFO, so the presented value stays stable.
    assign w_empty    = (r_count == 2'd0);
    assign w_valid    = !w_empty || r_inflight;
    assign w_head     = w_empty ? {fb_data_i, r_if_sof, r_if_eol} : r_mem[r_rd_ptr];
    assign w_pop      = w_valid && pixel_ready_i;
    assign w_fifo_pop = w_pop && !w_empty;
    assign w_push     = r_inflight && !(w_pop && w_empty);
    assign w_pending  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_read     = (r_state == S_READ) && (r_gap == '0) && (w_pending < 3'd2);

    assign fb_read_o     = w_read;
    assign fb_addr_o     = r_addr;
    assign pixel_valid_o = w_valid;
    assign pixel_data_o  = w_valid ? w_head[ENTRY_W-1:2] : '0;
    assign pixel_sof_o   = w_valid && w_head[1];
    assign pixel_eol_o   = w_valid && w_head[0];
    // Drops in the same cycle DRAIN decides to return to IDLE.
    assign busy_o        = (r_state != S_IDLE) &&
                           !((r_state == S_DRAIN) && w_empty && !r_inflight);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_col      <= '0;
            r_gap      <= '0;
            r_inflight <= 1'b0;
            r_if_sof   <= 1'b0;
            r_if_eol   <= 1'b0;
        end else begin
            r_inflight <= w_read;
            if (w_read) begin
                r_if_sof <= (r_addr == '0);
                r_if_eol <= (r_col == LAST_COL);
            end
            case (r_state)
                S_IDLE: begin
                    if (frame_start_i) begin
                        r_addr  <= '0;
                        r_col   <= '0;
                        r_gap   <= '0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_read) begin
                        r_addr <= r_addr + 1'b1;
                        r_col  <= (r_col == LAST_COL) ? '0 : r_col + 1'b1;
                        if (r_addr == LAST_ADDR) begin
                            r_state <= S_DRAIN;
                        end
                    end
`ifdef FB_READER_LINE_GAP_EN
                    if (w_read && (r_addr != LAST_ADDR) && (r_col == LAST_COL)) begin
                        r_gap <= GAP_W'(LINE_GAP_CYCLES);
                    end else if (r_gap != '0) begin
                        r_gap <= r_gap - 1'b1;
                    end
`endif
                end
                S_DRAIN: begin
                    if (w_empty && !r_inflight) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {fb_data_i, r_if_sof, r_if_eol};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_fifo_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_fifo_pop};
        end
    end

endmodule

// File: tb/tb_frame_buffer_reader.sv
module tb_frame_buffer_reader;

    localparam int PW  = 4;
    localparam int PPL = 160;
    localparam int LPF = 120;
    localparam int PPF = PPL * LPF;
    localparam int AW  = $clog2(PPF);
    localparam int GAP = 4;
`ifdef FB_READER_LINE_GAP_EN
    localparam int EG = GAP;
`else
    localparam int EG = 0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          frame_start_i;
    logic          fb_read_o;
    logic [AW-1:0] fb_addr_o;
    logic [PW-1:0] fb_data_i;
    logic          pixel_valid_o;
    logic          pixel_ready_i;
    logic [PW-1:0] pixel_data_o;
    logic          pixel_sof_o;
    logic          pixel_eol_o;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;

    logic [PW-1:0] img [PPF];

    always #5 clk_i = ~clk_i;

    frame_buffer_reader #(
        .PIXEL_WIDTH     (PW),
        .PIXELS_PER_LINE (PPL),
        .LINES_PER_FRAME (LPF),
        .LINE_GAP_CYCLES (GAP)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .frame_start_i (frame_start_i),
        .fb_read_o     (fb_read_o),
        .fb_addr_o     (fb_addr_o),
        .fb_data_i     (fb_data_i),
        .pixel_valid_o (pixel_valid_o),
        .pixel_ready_i (pixel_ready_i),
        .pixel_data_o  (pixel_data_o),
        .pixel_sof_o   (pixel_sof_o),
        .pixel_eol_o   (pixel_eol_o),
        .busy_o        (busy_o)
    );

    // Synchronous-read frame buffer: data for a read seen in one cycle is
    // driven for the whole next cycle; otherwise the bus carries noise.
    initial begin : fb_model
        logic          m_pend;
        logic [AW-1:0] m_addr;
        fb_data_i = '0;
        forever begin
            @(negedge clk_i);
            m_pend = (fb_read_o === 1'b1);
            m_addr = fb_addr_o;
            @(posedge clk_i);
            #1;
            fb_data_i = m_pend ? img[m_addr] : PW'($urandom);
        end
    end

    task automatic apply_reset();
        @(negedge clk_i);
        rst_n_i       = 1'b0;
        frame_start_i = 1'b0;
        pixel_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    // Leaves the caller 1 time unit after the edge that begins cycle T+1.
    task automatic pulse_start(input logic rdy);
        @(posedge clk_i);
        #1;
        frame_start_i = 1'b1;
        pixel_ready_i = rdy;
        @(posedge clk_i);
        #1;
        frame_start_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        rst_n_i       = 1'b0;
        frame_start_i = 1'b1;
        pixel_ready_i = 1'b1;
        #2;
        checks++;
        if ({fb_read_o, fb_addr_o, pixel_valid_o, pixel_data_o, pixel_sof_o, pixel_eol_o, busy_o} !== '0)
            begin failures++; $display("FAIL reset_outputs got=%h exp=0",
                {fb_read_o, fb_addr_o, pixel_valid_o, pixel_data_o, pixel_sof_o, pixel_eol_o, busy_o}); end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        frame_start_i = 1'b0;
        rst_n_i       = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            checks++;
            if ({fb_read_o, pixel_valid_o, busy_o, fb_addr_o} !== '0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got read=%b valid=%b busy=%b addr=%0d exp all 0",
                         c, fb_read_o, pixel_valid_o, busy_o, fb_addr_o);
            end
        end
    endtask

    // Ready held high: read of address a is due at cycle 1+a (plus line
    // gaps), its pixel one cycle later, busy until the last pixel's cycle.
    task automatic test_full_frame();
        int   c, na, np, last_c;
        logic exp_rd, exp_v, exp_b, done;
        apply_reset();
        for (int a = 0; a < PPF; a++) img[a] = PW'($urandom);
        last_c = 2 + (PPF - 1) + (LPF - 1) * EG;
        pulse_start(1'b1);
        c = 1; na = 0; np = 0; done = 1'b0;
        while (!done && c <= last_c + 10) begin
            @(negedge clk_i);
            exp_rd = (na < PPF) && (c == 1 + na + (na / PPL) * EG);
            checks++;
            if (fb_read_o !== exp_rd) begin
                failures++;
                $display("FAIL full_read cycle=%0d got=%b exp=%b", c, fb_read_o, exp_rd);
            end
            if (exp_rd) begin
                checks++;
                if (fb_addr_o !== AW'(na)) begin
                    failures++;
                    $display("FAIL full_addr cycle=%0d got=%0d exp=%0d", c, fb_addr_o, na);
                end
                na++;
            end
            exp_v = (np < PPF) && (c == 2 + np + (np / PPL) * EG);
            checks++;
            if (pixel_valid_o !== exp_v) begin
                failures++;
                $display("FAIL full_valid cycle=%0d got=%b exp=%b", c, pixel_valid_o, exp_v);
            end
            if (exp_v) begin
                checks++;
                if ({pixel_data_o, pixel_sof_o, pixel_eol_o} !==
                    {img[np], np == 0, (np % PPL) == PPL - 1}) begin
                    failures++;
                    $display("FAIL full_pixel idx=%0d got data=%h sof=%b eol=%b exp data=%h sof=%b eol=%b",
                             np, pixel_data_o, pixel_sof_o, pixel_eol_o,
                             img[np], np == 0, (np % PPL) == PPL - 1);
                end
                np++;
            end
            exp_b = (c <= last_c);
            checks++;
            if (busy_o !== exp_b) begin
                failures++;
                $display("FAIL full_busy cycle=%0d got=%b exp=%b", c, busy_o, exp_b);
            end
            if (c == last_c + 1) done = 1'b1;
            @(posedge clk_i);
            #1;
            c++;
        end
    endtask

    // Random ready; the model tracks reads issued and pixels taken.
    task automatic test_backpressure();
        int            c, reads, xfers, outst;
        logic          pop, exp_rd, prev_stall, done;
        logic [PW-1:0] pd;
        logic          ps, pe;
        apply_reset();
        for (int a = 0; a < PPF; a++) img[a] = PW'(a % 16);
        pulse_start(1'($urandom_range(0, 1)));
        reads = 0; xfers = 0; prev_stall = 1'b0; done = 1'b0; c = 1;
        pd = '0; ps = 1'b0; pe = 1'b0;
        while (!done && c < 10 * PPF) begin
            @(negedge clk_i);
            outst  = reads - xfers;
            pop    = pixel_valid_o && pixel_ready_i;
            exp_rd = (reads < PPF) && (outst - int'(pop) < 2);
            checks++;
`ifdef FB_READER_LINE_GAP_EN
            if (fb_read_o === 1'b1 && !exp_rd) begin
`else
            if (fb_read_o !== exp_rd) begin
`endif
                failures++;
                $display("FAIL bp_read cycle=%0d got=%b exp=%b outstanding=%0d", c, fb_read_o, exp_rd, outst);
            end
            if (fb_read_o === 1'b1) begin
                checks++;
                if (fb_addr_o !== AW'(reads)) begin
                    failures++;
                    $display("FAIL bp_addr cycle=%0d got=%0d exp=%0d", c, fb_addr_o, reads);
                end
                reads++;
            end
            checks++;
            if (pixel_valid_o !== (outst > 0)) begin
                failures++;
                $display("FAIL bp_valid cycle=%0d got=%b exp=%b", c, pixel_valid_o, outst > 0);
            end
            checks++;
            if (busy_o !== (xfers < PPF)) begin
                failures++;
                $display("FAIL bp_busy cycle=%0d got=%b exp=%b", c, busy_o, xfers < PPF);
            end
            if (prev_stall) begin
                checks++;
                if ({pixel_data_o, pixel_sof_o, pixel_eol_o} !== {pd, ps, pe}) begin
                    failures++;
                    $display("FAIL bp_stable cycle=%0d got=%h/%b/%b exp=%h/%b/%b",
                             c, pixel_data_o, pixel_sof_o, pixel_eol_o, pd, ps, pe);
                end
            end
            if (xfers == PPF) done = 1'b1;
            if (pop) begin
                checks++;
                if ({pixel_data_o, pixel_sof_o, pixel_eol_o} !==
                    {PW'(xfers % 16), xfers == 0, (xfers % PPL) == PPL - 1}) begin
                    failures++;
                    $display("FAIL bp_pixel idx=%0d got data=%h sof=%b eol=%b exp data=%h sof=%b eol=%b",
                             xfers, pixel_data_o, pixel_sof_o, pixel_eol_o,
                             PW'(xfers % 16), xfers == 0, (xfers % PPL) == PPL - 1);
                end
                xfers++;
            end
            prev_stall = pixel_valid_o && !pixel_ready_i;
            pd = pixel_data_o; ps = pixel_sof_o; pe = pixel_eol_o;
            @(posedge clk_i);
            #1;
            pixel_ready_i = 1'($urandom_range(0, 1));
            c++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL bp_timeout got pixels=%0d exp=%0d", xfers, PPF);
        end
    endtask

    task automatic test_stall_start();
        int nreads;
        apply_reset();
        for (int a = 0; a < PPF; a++) img[a] = PW'($urandom);
        pulse_start(1'b0);
        nreads = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk_i);
            if (fb_read_o === 1'b1) begin
                checks++;
                if (fb_addr_o !== AW'(nreads)) begin
                    failures++;
                    $display("FAIL stall_addr cycle=%0d got=%0d exp=%0d", c, fb_addr_o, nreads);
                end
                nreads++;
            end
            checks++;
            if (pixel_valid_o !== (c >= 2)) begin
                failures++;
                $display("FAIL stall_valid cycle=%0d got=%b exp=%b", c, pixel_valid_o, c >= 2);
            end
            @(posedge clk_i);
            #1;
        end
        checks++;
        if (nreads != 2) begin
            failures++;
            $display("FAIL stall_reads got=%0d exp=2", nreads);
        end
        pixel_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({fb_read_o, fb_addr_o} !== {1'b1, AW'(2)}) begin
            failures++;
            $display("FAIL stall_resume got read=%b addr=%0d exp read=1 addr=2", fb_read_o, fb_addr_o);
        end
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin
                @(posedge clk_i);
                #1;
                @(negedge clk_i);
            end
            checks++;
            if ({pixel_valid_o, pixel_data_o, pixel_sof_o} !== {1'b1, img[k], k == 0}) begin
                failures++;
                $display("FAIL stall_pixel idx=%0d got v=%b data=%h sof=%b exp v=1 data=%h sof=%b",
                         k, pixel_valid_o, pixel_data_o, pixel_sof_o, img[k], k == 0);
            end
        end
    endtask

    task automatic test_midframe();
        int   np, nr, c;
        logic hit, pulsed;
        apply_reset();
        for (int a = 0; a < PPF; a++) img[a] = PW'($urandom);
        pulse_start(1'b1);
        np = 0; nr = 0; c = 0; hit = 1'b0; pulsed = 1'b0;
        while (!hit && c < 3000) begin
            @(negedge clk_i);
            if (fb_read_o === 1'b1) begin
                checks++;
                if (fb_addr_o !== AW'(nr)) begin
                    failures++;
                    $display("FAIL mid_addr got=%0d exp=%0d", fb_addr_o, nr);
                end
                nr++;
            end
            if (pixel_valid_o && pixel_ready_i) begin
                checks++;
                if ({pixel_data_o, pixel_sof_o, pixel_eol_o} !==
                    {img[np], np == 0, (np % PPL) == PPL - 1}) begin
                    failures++;
                    $display("FAIL mid_pixel idx=%0d got data=%h sof=%b eol=%b exp data=%h sof=%b eol=%b",
                             np, pixel_data_o, pixel_sof_o, pixel_eol_o,
                             img[np], np == 0, (np % PPL) == PPL - 1);
                end
                np++;
            end
            if (np == 1001) begin
                #1;
                rst_n_i = 1'b0;
                #1;
                checks++;
                if ({fb_read_o, fb_addr_o, pixel_valid_o, pixel_data_o, pixel_sof_o, pixel_eol_o, busy_o} !== '0)
                    begin failures++; $display("FAIL mid_reset_outputs got=%h exp=0",
                        {fb_read_o, fb_addr_o, pixel_valid_o, pixel_data_o, pixel_sof_o, pixel_eol_o, busy_o}); end
                hit = 1'b1;
            end else begin
                @(posedge clk_i);
                #1;
                frame_start_i = (np == 501) && !pulsed;
                if (np == 501) pulsed = 1'b1;
                c++;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL mid_timeout got pixels=%0d exp=1001", np);
        end
        frame_start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        pulse_start(1'b1);
        @(negedge clk_i);
        checks++;
        if ({fb_read_o, fb_addr_o, pixel_valid_o} !== {1'b1, AW'(0), 1'b0}) begin
            failures++;
            $display("FAIL restart_read got read=%b addr=%0d valid=%b exp read=1 addr=0 valid=0",
                     fb_read_o, fb_addr_o, pixel_valid_o);
        end
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        checks++;
        if ({pixel_valid_o, pixel_sof_o, pixel_data_o} !== {1'b1, 1'b1, img[0]}) begin
            failures++;
            $display("FAIL restart_pixel got v=%b sof=%b data=%h exp v=1 sof=1 data=%h",
                     pixel_valid_o, pixel_sof_o, pixel_data_o, img[0]);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i       = 1'b1;
        frame_start_i = 1'b0;
        pixel_ready_i = 1'b0;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_stall_start();
        test_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
